// File: rtl/freq_counter_initiator.sv
// Wishbone initiator that runs one reset/start/poll/read/clear measurement on a frequency counter.
// Define FREQ_COUNTER_INITIATOR_TIMEOUT_EN to abort transfers that see no ack_i/err_i within ACK_TIMEOUT strobe cycles.
module freq_counter_initiator #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        start_i,
    output logic [31:0] count_o,
    output logic [9:0]  phase_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        error_o
);

    localparam int unsigned CW = 16;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WR_RST = 4'd1;
    localparam logic [3:0] S_WR_GO  = 4'd2;
    localparam logic [3:0] S_POLL   = 4'd3;
    localparam logic [3:0] S_GAP    = 4'd4;
    localparam logic [3:0] S_RD_CNT = 4'd5;
    localparam logic [3:0] S_RD_PH  = 4'd6;
    localparam logic [3:0] S_WR_CLR = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;
    localparam logic [3:0] S_FAULT  = 4'd9;

    if (POLL_GAP == 0 || POLL_GAP > 65535) begin : g_bad_poll_gap
        $error("POLL_GAP must be in 1..65535");
    end
    if (ACK_TIMEOUT == 0 || ACK_TIMEOUT > 65535) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be in 1..65535");
    end

    logic [3:0]    state_q, state_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          first_q, first_d;
    logic          arm_q, arm_d;
    logic [CW-1:0] gap_q, gap_d;
    logic [31:0]   count_q, count_d;
    logic [9:0]    phase_q, phase_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
    logic [CW-1:0] to_q, to_d;
`endif

    logic          tx_c;
    logic          tx_we_c;
    logic [3:0]    tx_off_c;
    logic [31:0]   tx_dat_c;
    logic          ack_c;
    logic          err_c;
    logic          to_hit_c;

    // Transfer descriptor for the bus states
    always_comb begin
        tx_c     = 1'b1;
        tx_we_c  = 1'b0;
        tx_off_c = 4'h8;
        tx_dat_c = 32'h0;
        case (state_q)
            S_WR_RST: begin tx_we_c = 1'b1; tx_dat_c = 32'h01; end
            S_WR_GO:  begin tx_we_c = 1'b1; tx_dat_c = 32'h80; end
            S_POLL:   ;
            S_RD_CNT: tx_off_c = 4'h9;
            S_RD_PH:  tx_off_c = 4'hA;
            S_WR_CLR: tx_we_c = 1'b1;
            default:  tx_c = 1'b0;
        endcase
    end

    // The first strobe cycle never completes: the responder's ack may be left over from the last transfer
    assign err_c = stb_q && !first_q && err_i;
    assign ack_c = stb_q && !first_q && ack_i && !err_i;

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        first_d  = first_q;
        arm_d    = arm_q;
        gap_d    = gap_q;
        count_d  = count_q;
        phase_d  = phase_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        error_d  = error_q;
        to_hit_c = 1'b0;
`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
        to_d     = to_q;
`endif

        if (tx_c) begin
            if (!stb_q) begin
                // One armed idle cycle keeps the bus low between transfers
                if (arm_q) begin
                    stb_d   = 1'b1;
                    first_d = 1'b1;
                    arm_d   = 1'b0;
                    we_d    = tx_we_c;
                    adr_d   = BASE_ADDR + 32'(tx_off_c);
                    dat_d   = tx_dat_c;
                    sel_d   = 4'hF;
`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
                    to_d    = '0;
`endif
                end else begin
                    arm_d = 1'b1;
                end
            end else begin
                first_d = 1'b0;
`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
                to_d     = to_q + CW'(1);
                to_hit_c = !ack_c && !err_c && (to_q == CW'(ACK_TIMEOUT - 1));
`endif
                if (ack_c || err_c || to_hit_c) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    adr_d = 32'h0;
                    dat_d = 32'h0;
                    sel_d = 4'h0;
                end
                if (err_c || to_hit_c) begin
                    state_d = S_FAULT;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (ack_c) begin
                    case (state_q)
                        S_WR_RST: state_d = S_WR_GO;
                        S_WR_GO:  state_d = S_POLL;
                        S_POLL: begin
                            if (dat_i[6]) begin
                                state_d = S_RD_CNT;
                            end else begin
                                state_d = S_GAP;
                                gap_d   = '0;
                            end
                        end
                        S_RD_CNT: begin
                            count_d = dat_i;
                            state_d = S_RD_PH;
                        end
                        S_RD_PH: begin
                            phase_d = dat_i[9:0];
                            state_d = S_WR_CLR;
                        end
                        default:  state_d = S_DONE;
                    endcase
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_WR_RST;
                        busy_d  = 1'b1;
                        arm_d   = 1'b0;
                    end
                end
                S_FAULT: begin
                    if (start_i) begin
                        state_d = S_WR_RST;
                        busy_d  = 1'b1;
                        error_d = 1'b0;
                        arm_d   = 1'b0;
                    end
                end
                S_GAP: begin
                    // The last idle cycle launches the next poll so the bus is low exactly POLL_GAP cycles
                    if (gap_q == CW'(POLL_GAP - 1)) begin
                        gap_d   = '0;
                        state_d = S_POLL;
                        stb_d   = 1'b1;
                        first_d = 1'b1;
                        we_d    = 1'b0;
                        adr_d   = BASE_ADDR + 32'h8;
                        dat_d   = 32'h0;
                        sel_d   = 4'hF;
`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end else begin
                        gap_d = gap_q + CW'(1);
                    end
                end
                S_DONE: begin
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            sel_q   <= 4'h0;
            first_q <= 1'b0;
            arm_q   <= 1'b0;
            gap_q   <= '0;
            count_q <= 32'h0;
            phase_q <= 10'h0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            arm_q   <= arm_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            error_q <= error_d;
`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign sel_o   = sel_q;
    assign we_o    = we_q;
    assign cyc_o   = stb_q;
    assign stb_o   = stb_q;
    assign count_o = count_q;
    assign phase_o = phase_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_freq_counter_initiator.sv
// Scoreboard bench for freq_counter_initiator: expected bus transfers and results are queued, a monitor checks them.
module tb_freq_counter_initiator;

    localparam logic [31:0] BA = 32'h4000_0100;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          gap;
    } txn_t;

    typedef struct {
        logic [31:0] cnt;
        logic [9:0]  ph;
    } res_t;

    logic        clk_i, rst_i;
    logic [31:0] adr_o, dat_o, dat_i, count_o;
    logic [3:0]  sel_o;
    logic        we_o, cyc_o, stb_o, ack_i, err_i, start_i;
    logic [9:0]  phase_o;
    logic        valid_o, busy_o, error_o;

    int checks = 0;
    int errors = 0;

    txn_t exp_q[$];
    res_t res_q[$];

    // Responder controls
    logic        stale_ack = 1'b0;
    logic        err_on    = 1'b0;
    logic [31:0] err_adr   = 32'h0;
    logic        hang_on   = 1'b0;
    int          hang_len  = 0;
    int          poll_n    = 0;
    int          poll_ok_at = 1;
    logic [31:0] cnt_val   = 32'h0;
    logic [31:0] ph_word   = 32'h0;
    logic        allow_abort = 1'b0;
    int          last_abort = 0;

    freq_counter_initiator #(
        .BASE_ADDR  (BA),
        .POLL_GAP   (16),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adr_o  (adr_o),
        .dat_o  (dat_o),
        .sel_o  (sel_o),
        .we_o   (we_o),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .dat_i  (dat_i),
        .ack_i  (ack_i),
        .err_i  (err_i),
        .start_i(start_i),
        .count_o(count_o),
        .phase_o(phase_o),
        .valid_o(valid_o),
        .busy_o (busy_o),
        .error_o(error_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [3:0] off, input logic we, input logic [31:0] dat, input int gap);
        txn_t t;
        t.adr = BA + 32'(off);
        t.we  = we;
        t.dat = dat;
        t.gap = gap;
        exp_q.push_back(t);
    endtask

    task automatic push_res(input logic [31:0] cnt, input logic [9:0] ph);
        res_t r;
        r.cnt = cnt;
        r.ph  = ph;
        res_q.push_back(r);
    endtask

    task automatic push_short_run();
        push_txn(4'h8, 1'b1, 32'h01, -1);
        push_txn(4'h8, 1'b1, 32'h80, -1);
        push_txn(4'h8, 1'b0, 32'h0, -1);
        push_txn(4'h9, 1'b0, 32'h0, -1);
        push_txn(4'hA, 1'b0, 32'h0, -1);
        push_txn(4'h8, 1'b1, 32'h00, -1);
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || res_q.size() != 0) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout with %0d transfers and %0d results outstanding, required 0",
                     name, exp_q.size(), res_q.size());
            exp_q.delete();
            res_q.delete();
        end
        repeat (5) @(negedge clk_i);
    endtask

    task automatic wait_stb_adr(input logic [31:0] adr, input string name);
        int n = 0;
        while (!(stb_o === 1'b1 && adr_o === adr) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s: strobe to 0x%0h never seen, required within 500 cycles", name, adr);
        end
    endtask

    // Responder: registered-style ack on the second strobe cycle unless told otherwise
    initial begin : responder
        int rn;
        logic hit_err, hung;
        rn = 0;
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i || !stb_o) begin
                rn    = 0;
                ack_i = stale_ack;
                err_i = 1'b0;
                dat_i = 32'hDEAD_BEEF;
            end else begin
                rn++;
                if (rn == 1 && !we_o && adr_o == BA + 32'h8) poll_n++;
                hit_err = err_on && !we_o && adr_o == err_adr && rn >= 2;
                hung    = hang_on && we_o && dat_o == 32'h80 && rn < hang_len;
                ack_i   = stale_ack || (rn >= 2 && !hung);
                err_i   = hit_err;
                if (adr_o == BA + 32'h8)      dat_i = (poll_n >= poll_ok_at) ? 32'h0000_0040 : 32'hFFFF_FFBF;
                else if (adr_o == BA + 32'h9) dat_i = cnt_val;
                else if (adr_o == BA + 32'hA) dat_i = ph_word;
                else                          dat_i = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: checks every completed transfer and every result strobe against the queues
    initial begin : monitor
        int c, low, gap_seen, vrun;
        logic done_t;
        logic [31:0] cap_adr, cap_dat;
        logic cap_we;
        txn_t e;
        res_t r;
        c = 0; low = 1000; gap_seen = 0; vrun = 0; done_t = 1'b0;
        cap_adr = 32'h0; cap_dat = 32'h0; cap_we = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                c = 0; low = 1000; vrun = 0; done_t = 1'b0;
            end else begin
                if (stb_o) begin
                    if (c == 0) begin
                        cap_adr = adr_o; cap_dat = dat_o; cap_we = we_o; gap_seen = low;
                    end else begin
                        chk("stable_adr", adr_o, cap_adr);
                        chk("stable_dat", dat_o, cap_dat);
                        chk("stable_we", 32'(we_o), 32'(cap_we));
                    end
                    c++;
                    chk("cyc_sel", {27'h0, cyc_o, sel_o}, {27'h0, 1'b1, 4'hF});
                    if (c >= 2 && (ack_i || err_i) && !done_t) begin
                        done_t = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_txn: adr 0x%0h we %0d, required no transfer", adr_o, we_o);
                        end else begin
                            e = exp_q.pop_front();
                            chk("txn_adr", adr_o, e.adr);
                            chk("txn_we", 32'(we_o), 32'(e.we));
                            if (e.we) chk("txn_dat", dat_o, e.dat);
                            if (e.gap >= 0) chk("txn_gap", 32'(gap_seen), 32'(e.gap));
                            else            chk("txn_gap_min", 32'(gap_seen >= 1), 32'h1);
                        end
                    end
                end else begin
                    if (c > 0) begin
                        if (!done_t) begin
                            if (allow_abort) begin
                                last_abort = c;
                            end else begin
                                checks++; errors++;
                                $display("FAIL early_end: strobe dropped after %0d cycles without completion, required ack", c);
                            end
                        end
                        low = 0;
                    end
                    low++;
                    c = 0;
                    done_t = 1'b0;
                end
                if (valid_o) begin
                    vrun++;
                    if (vrun == 1) begin
                        if (res_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_valid: count 0x%0h, required no valid", count_o);
                        end else begin
                            r = res_q.pop_front();
                            chk("res_count", count_o, r.cnt);
                            chk("res_phase", 32'(phase_o), 32'(r.ph));
                            chk("res_busy", 32'(busy_o), 32'h0);
                        end
                    end else begin
                        chk("valid_width", 32'(vrun), 32'h1);
                    end
                end else begin
                    vrun = 0;
                end
            end
        end
    end

    initial begin : stimulus
        start_i = 1'b0;
        rst_i   = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_adr", adr_o, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_bus", {28'h0, sel_o, cyc_o, stb_o, we_o} >> 0, 32'h0);
        chk("rst_count", count_o, 32'h0);
        chk("rst_phase", 32'(phase_o), 32'h0);
        chk("rst_flags", {29'h0, valid_o, busy_o, error_o}, 32'h0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Full measurement: ready on 3rd poll, extra starts while busy are ignored
        poll_n = 0; poll_ok_at = 3; cnt_val = 32'd100000; ph_word = 32'hABCD_EEA5;
        push_txn(4'h8, 1'b1, 32'h01, -1);
        push_txn(4'h8, 1'b1, 32'h80, -1);
        push_txn(4'h8, 1'b0, 32'h0, -1);
        push_txn(4'h8, 1'b0, 32'h0, 16);
        push_txn(4'h8, 1'b0, 32'h0, 16);
        push_txn(4'h9, 1'b0, 32'h0, -1);
        push_txn(4'hA, 1'b0, 32'h0, -1);
        push_txn(4'h8, 1'b1, 32'h00, -1);
        push_res(32'd100000, 10'h2A5);
        pulse_start();
        chk("busy_after_start", 32'(busy_o), 32'h1);
        repeat (10) @(negedge clk_i);
        pulse_start();
        repeat (20) @(negedge clk_i);
        pulse_start();
        wait_done(2000, "run_basic");
        repeat (60) @(negedge clk_i);
        chk("hold_count", count_o, 32'd100000);
        chk("hold_phase", 32'(phase_o), 32'h2A5);

        // Stale ack held high throughout
        stale_ack = 1'b1; poll_n = 0; poll_ok_at = 1; cnt_val = 32'h1234_5678; ph_word = 32'h0000_0155;
        push_short_run();
        push_res(32'h1234_5678, 10'h155);
        pulse_start();
        wait_done(2000, "run_stale");
        stale_ack = 1'b0;
        repeat (3) @(negedge clk_i);

        // err_i (with ack_i) on RD_CNT, then restart from FAULT
        err_on = 1'b1; err_adr = BA + 32'h9; poll_n = 0; cnt_val = 32'hCAFE_0001;
        push_txn(4'h8, 1'b1, 32'h01, -1);
        push_txn(4'h8, 1'b1, 32'h80, -1);
        push_txn(4'h8, 1'b0, 32'h0, -1);
        push_txn(4'h9, 1'b0, 32'h0, -1);
        pulse_start();
        wait_done(2000, "run_err");
        chk("fault_error", 32'(error_o), 32'h1);
        chk("fault_busy", 32'(busy_o), 32'h0);
        chk("fault_stb", 32'(stb_o), 32'h0);
        chk("fault_count", count_o, 32'h1234_5678);
        chk("fault_phase", 32'(phase_o), 32'h155);
        err_on = 1'b0; poll_n = 0; cnt_val = 32'd7777; ph_word = 32'hFFFF_FFFF;
        push_short_run();
        push_res(32'd7777, 10'h3FF);
        pulse_start();
        @(negedge clk_i);
        chk("restart_error", 32'(error_o), 32'h0);
        chk("restart_busy", 32'(busy_o), 32'h1);
        wait_done(2000, "run_restart");

`ifdef FREQ_COUNTER_INITIATOR_TIMEOUT_EN
        // No ack on WR_GO: aborted after ACK_TIMEOUT strobe cycles
        hang_on = 1'b1; hang_len = 1000; allow_abort = 1'b1; poll_n = 0;
        push_txn(4'h8, 1'b1, 32'h01, -1);
        pulse_start();
        repeat (40) @(negedge clk_i);
        chk("timeout_error", 32'(error_o), 32'h1);
        chk("timeout_stb", 32'(stb_o), 32'h0);
        chk("timeout_len", 32'(last_abort), 32'h8);
        chk("timeout_queue", 32'(exp_q.size()), 32'h0);
        hang_on = 1'b0; allow_abort = 1'b0;
        exp_q.delete();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
`else
        // No ack on WR_GO: strobe held until the responder finally acks
        hang_on = 1'b1; hang_len = 300; poll_n = 0; cnt_val = 32'd42; ph_word = 32'h0000_0001;
        push_short_run();
        push_res(32'd42, 10'h001);
        pulse_start();
        wait_stb_adr(BA + 32'h8, "hang_wait");
        while (!(stb_o && we_o && dat_o == 32'h80)) @(negedge clk_i);
        repeat (290) @(negedge clk_i);
        chk("hang_stb", 32'(stb_o), 32'h1);
        chk("hang_dat", dat_o, 32'h80);
        wait_done(2000, "run_hang");
        hang_on = 1'b0;
`endif

        // Reset asserted during the RD_PH strobe
        poll_n = 0; cnt_val = 32'd555; ph_word = 32'h0000_0123;
        push_short_run();
        push_res(32'd555, 10'h123);
        pulse_start();
        wait_stb_adr(BA + 32'hA, "rdph_wait");
        rst_i = 1'b1;
        #1;
        chk("mrst_adr", adr_o, 32'h0);
        chk("mrst_dat", dat_o, 32'h0);
        chk("mrst_bus", {28'h0, sel_o, cyc_o, stb_o, we_o} >> 0, 32'h0);
        chk("mrst_count", count_o, 32'h0);
        chk("mrst_flags", {29'h0, valid_o, busy_o, error_o}, 32'h0);
        exp_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        chk("post_rst_count", count_o, 32'h0);
        chk("post_rst_phase", 32'(phase_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_counter_initiator.md
FREQ_COUNTER_INITIATOR -- requirements
Module: freq_counter_initiator

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, meaning: offset added to register addresses 0x8 (control), 0x9 (count), 0xA (phase).
REQ-002 SHALL have parameter POLL_GAP, default 16, meaning: idle cycles between consecutive status polls (1..65535).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, meaning: strobe cycles without ack_i before abort (1..65535).
REQ-004 SHALL have port clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports adr_o out 32, dat_o out 32, sel_o out 4, we_o out 1, cyc_o out 1, stb_o out 1: Wishbone initiator outputs.
REQ-007 SHALL have ports dat_i in 32, ack_i in 1, err_i in 1: Wishbone initiator inputs.
REQ-008 SHALL have ports start_i in 1 (measurement request), count_o out 32 (coarse count), phase_o out 10 (phase bits [9:0]).
REQ-009 SHALL have ports valid_o out 1 (one-cycle result strobe), busy_o out 1 (sequence active), error_o out 1 (sticky fault).

Function
REQ-010 SHALL run states IDLE, WR_RST, WR_GO, POLL, GAP, RD_CNT, RD_PH, WR_CLR, DONE, FAULT.
REQ-011 IDLE: start_i=1 -> WR_RST, busy_o=1 from the next cycle; start_i ignored in all other states.
REQ-012 WR_RST: write 32'h01 to BASE_ADDR+8 -> WR_GO.
REQ-013 WR_GO: write 32'h80 to BASE_ADDR+8 -> POLL.
REQ-014 POLL: read BASE_ADDR+8; dat_i[6]=1 -> RD_CNT; else -> GAP.
REQ-015 GAP: bus idle for exactly POLL_GAP cycles -> POLL.
REQ-016 RD_CNT: read BASE_ADDR+9, capture dat_i into count register -> RD_PH.
REQ-017 RD_PH: read BASE_ADDR+10, capture dat_i[9:0] into phase register -> WR_CLR.
REQ-018 WR_CLR: write 32'h00 to BASE_ADDR+8 -> DONE.
REQ-019 DONE: valid_o=1 for exactly one cycle, busy_o=0 -> IDLE.
REQ-020 Every transfer: cyc_o=stb_o=1, sel_o=4'hF, we_o=1 for writes, 0 for reads; adr_o/dat_o/we_o stable while stb_o=1.
REQ-021 ack_i/err_i SHALL be ignored on the first strobe cycle and sampled from the second onward (responder ack is registered and may be stale).
REQ-022 Transfer ends on the cycle ack_i or err_i is sampled high; stb_o and cyc_o SHALL drop the next cycle and stay low at least one cycle before the next transfer.
REQ-023 ack_i and err_i sampled high together SHALL count as err_i.
REQ-024 err_i during any transfer -> FAULT: error_o=1, busy_o=0, bus idle; count_o/phase_o keep previous values.
REQ-025 FAULT: start_i=1 clears error_o and enters WR_RST.
REQ-026 count_o/phase_o SHALL update only in RD_CNT/RD_PH and hold between measurements.
REQ-027 Register writes SHALL carry dat_o[31:8]=0.

Reset
REQ-028 rst_i=1 SHALL immediately force IDLE, cyc_o=stb_o=we_o=0, adr_o=dat_o=0, sel_o=0, count_o=0, phase_o=0, valid_o=busy_o=error_o=0, gap/timeout counters=0.
REQ-029 Reset mid-transfer SHALL abandon the transfer without completing its write or capture.
REQ-030 First transfer after reset release SHALL begin no earlier than the second clock edge after start_i is sampled.

Configuration
REQ-031 Macro FREQ_COUNTER_INITIATOR_TIMEOUT_EN defined: timeout counter counts strobe cycles; reaching ACK_TIMEOUT without ack_i/err_i -> FAULT per REQ-024.
REQ-032 Macro undefined: no timeout counter; transfer waits for ack_i/err_i indefinitely; ACK_TIMEOUT unused.

Verification
REQ-033 Reset, start_i pulse, responder acks 2nd cycle, status bit6 set on 3rd poll, count=32'd100000, phase=10'h2A5 -> exact write/poll/read order, 2 GAP periods of 16 cycles, count_o=100000, phase_o=10'h2A5, valid_o one cycle.
REQ-034 Responder holds ack_i=1 from previous transfer -> first strobe cycle ignored, no transfer completes early.
REQ-035 err_i on RD_CNT -> error_o=1, busy_o=0, count_o unchanged; start_i -> error_o=0, sequence restarts at WR_RST.
REQ-036 Macro defined, ACK_TIMEOUT=8, no ack on WR_GO -> FAULT after 8 strobe cycles; macro undefined -> stb_o held high until ack_i.
REQ-037 rst_i asserted during RD_PH strobe -> bus outputs 0 same cycle, count_o=0, no valid_o.
REQ-038 start_i pulsed while busy_o=1 -> ignored, exactly one valid_o per accepted start.
